serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Multi-cycle controller that sequences a single 4-bit adder slice to add two wide operands one nibble per clock, holding the inter-nibble carry in a register. It sits between a requester and a consumer using valid/ready handshakes and trades throughput for area: one shared 4-bit adder serves any operand width. The datapath is the team's `full_adder4` slice (`a`, `b`, `c`, `so`, `co`), instantiated once inside this block.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; width W = 4*NIBBLES; legal range 1..16.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  request carries a valid operand pair.
- `in_ready`  output  1  block can accept a request; high only in IDLE.
- `a`  input  W  operand A; sampled only at the input handshake.
- `b`  input  W  operand B; sampled only at the input handshake.
- `cin`  input  1  initial carry-in; sampled only at the input handshake.
- `out_valid`  output  1  `sum`/`cout` are valid.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  W  result, a+b+cin mod 2^W.
- `cout`  output  1  carry out of the top nibble.
- `ovf`  output  1  signed overflow; present only with the macro below.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch `a` and `b` into operand registers;
  - carry register <= `cin`;
  - nibble index <= 0;
  - clear the sum register;
  - go to RUN.
- RUN: the adder is fed nibble[idx] of A, nibble[idx] of B and the carry register. Each clock:
  - sum nibble[idx] <= `so`;
  - carry <= `co`;
  - idx <= idx+1.
  - When idx==NIBBLES-1, go to DONE.
- DONE: `out_valid`=1, `cout`=carry register. On `out_ready`, go to IDLE.
- Index counter width is $clog2(NIBBLES) with a minimum of 1 bit; it never wraps past NIBBLES-1.
- Inputs `a`, `b` and `cin` are don't-care outside the handshake. Changing them during RUN has no effect.
- `sum`, `cout` and `ovf` are driven from registers and are stable for the whole DONE state.
- `in_valid` is not dropped by this block; a request presented in RUN or DONE waits until IDLE.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, idx=0, carry=0.
- Latency: handshake at edge E0; `out_valid` rises after edge E(NIBBLES), i.e. NIBBLES cycles later.
- Throughput: at most one result per NIBBLES+2 cycles (accept, NIBBLES adds, one DONE cycle with `out_ready` already high).
- `in_ready` is 0 throughout RUN and DONE. A new request cannot be accepted on the same edge a result is consumed.
- Backpressure: `out_ready` low holds DONE indefinitely with all outputs unchanged.
- Reset asserted in any state takes effect at the next edge: go to IDLE with all outputs at reset values. An in-flight operation is discarded, and no `out_valid` pulse follows.
- NIBBLES=1: RUN lasts exactly one cycle.

## Configuration
- `SERIAL_ADD_OVF_EN` defined: the `ovf` port exists.
  - `ovf` = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), evaluated on the latched operands.
  - It is registered at the RUN→DONE transition and valid with `out_valid`.
- Macro undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `serial_add_pkg`:
  - `NIBBLE_W`=4;
  - the state enum typedef (IDLE, RUN, DONE).
- One sub-module: `full_adder4`, a single instance, purely combinational.
- Everything else (FSM, operand, sum and carry registers, index counter) lives in `serial_add_ctrl`.

## Test plan
- NIBBLES=4, a=16'h0005, b=16'h0002, cin=0 → `sum`=16'h0007, `cout`=0; `out_valid` exactly 4 cycles after the handshake.
- a=16'hFFFF, b=16'h0001, cin=0 → `sum`=16'h0000, `cout`=1 (carry ripples through all four nibbles).
- a=16'h000A, b=16'h0008, cin=1 → `sum`=16'h0013, `cout`=0. With the macro: a=16'h7FFF, b=16'h0001 → `sum`=16'h8000, `ovf`=1.
- Hold `out_ready`=0 for 5 cycles in DONE, and toggle `a`/`b`/`in_valid` meanwhile → `sum` stable, `in_ready`=0 throughout; result accepted on the first `out_ready`.
- Assert `rst` for one cycle during the 2nd RUN cycle → next cycle `in_ready`=1, `out_valid`=0, `sum`=0; no result is ever emitted for that request.
- Back-to-back requests with `in_valid` held high and `out_ready`=1 → results every 6 cycles, in order, each correct.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants and FSM state type for the serial adder
//
// Purpose : common definitions imported by serial_add_ctrl and full_adder4.
// Contents: NIBBLE_W (adder slice width), state_e (IDLE, RUN, DONE).

package serial_add_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/full_adder4.sv
// rtl/full_adder4.sv - combinational 4-bit adder slice with carry in/out
//
// Purpose : one nibble of addition, shared by the serial controller.
// Ports   :
//   a  [3:0] in   addend nibble
//   b  [3:0] in   addend nibble
//   c        in   carry in
//   so [3:0] out  sum nibble
//   co       out  carry out

module full_adder4
   import serial_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                c,
   output logic [NIBBLE_W-1:0] so,
   output logic                co
);

   assign {co, so} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c};

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - nibble-serial wide adder controller with valid/ready handshakes
//
// Purpose : adds two W-bit operands (W = 4*NIBBLES) one nibble per clock through a
//           single full_adder4 instance, holding the inter-nibble carry in a register.
// Option  : SERIAL_ADD_OVF_EN adds the registered signed-overflow output ovf.
// Ports   :
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   in_valid       in   request valid
//   in_ready       out  request accepted (IDLE only)
//   a, b     [W-1] in   operands, sampled at the input handshake
//   cin            in   initial carry, sampled at the input handshake
//   out_valid      out  result valid (DONE)
//   out_ready      in   consumer accepts result
//   sum      [W-1] out  a+b+cin mod 2^W
//   cout           out  carry out of the top nibble
//   ovf            out  signed overflow (SERIAL_ADD_OVF_EN only)

module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0] a,
   input  logic [NIBBLE_W*NIBBLES-1:0] b,
   input  logic                        cin,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] sum,
   output logic                        cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic                        ovf
`endif
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_e              state_q, state_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        b_q, b_d;
   logic [W-1:0]        sum_q, sum_d;
   logic                carry_q, carry_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
`ifdef SERIAL_ADD_OVF_EN
   logic                ovf_q, ovf_d;
`endif

   logic [NIBBLE_W-1:0] fa_a, fa_b, fa_so;
   logic                fa_co;

   // Select nibble[idx] of each latched operand for the shared adder.
   always_comb begin
      fa_a = '0;
      fa_b = '0;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (idx_q == IDX_W'(i)) begin
            fa_a = a_q[i*NIBBLE_W +: NIBBLE_W];
            fa_b = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   full_adder4 u_fa (
      .a  (fa_a),
      .b  (fa_b),
      .c  (carry_q),
      .so (fa_so),
      .co (fa_co)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d     = ovf_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = RUN;
            end
         end

         RUN: begin
            for (int i = 0; i < int'(NIBBLES); i++) begin
               if (idx_q == IDX_W'(i)) begin
                  sum_d[i*NIBBLE_W +: NIBBLE_W] = fa_so;
               end
            end
            carry_d = fa_co;
            if (idx_q == IDX_LAST) begin
               // Index stops at the last nibble instead of wrapping.
               state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
               // Top nibble is being written this cycle, so its MSB comes from the adder.
               ovf_d = (a_q[W-1] == b_q[W-1]) && (fa_so[NIBBLE_W-1] != a_q[W-1]);
`endif
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign sum  = sum_q;
   assign cout = carry_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (NIBBLES=4)

module tb_serial_add_ctrl;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: W-bit sum plus carry as plain integer arithmetic.
   function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
      int unsigned t;
      t = int'(x) + int'(y) + int'(c);
      return (W+1)'(t);
   endfunction

   // Reference: signed overflow as the true signed result leaving the W-bit range.
   function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c);
      int r;
      r = int'($signed(x)) + int'($signed(y)) + int'(c);
      return (r > 32767) || (r < -32768);
   endfunction

   // Issues one request and waits for its result; reports latency and outputs.
   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         output int lat, output logic [W-1:0] rs, output logic rc,
                         output logic rv, output logic timed_out);
      @(negedge clk);
      a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      lat = 0;
      timed_out = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) begin
            timed_out = 1'b0;
            break;
         end
      end
      rs = sum;
      rc = cout;
`ifdef SERIAL_ADD_OVF_EN
      rv = ovf;
`else
      rv = 1'b0;
`endif
      if (!timed_out) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++;
      if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got %h want 0000", sum); end
      checks++;
      if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [4] = '{16'h0005, 16'hFFFF, 16'h000A, 16'h7FFF};
      logic [W-1:0] tb [4] = '{16'h0002, 16'h0001, 16'h0008, 16'h0001};
      logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [W:0]   want [4] = '{17'h00007, 17'h10000, 17'h00013, 17'h08000};
      int lat; logic [W-1:0] rs; logic rc, rv, to;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], tc[i], lat, rs, rc, rv, to);
         checks++;
         if (to) begin
            errors++; $display("FAIL directed_timeout[%0d] got no out_valid want out_valid", i);
            continue;
         end
         checks++;
         if (lat !== NIB) begin errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, NIB); end
         checks++;
         if ({rc, rs} !== want[i]) begin
            errors++; $display("FAIL directed_result[%0d] got %h want %h", i, {rc, rs}, want[i]);
         end
         checks++;
         if ({rc, rs} !== model_add(ta[i], tb[i], tc[i])) begin
            errors++; $display("FAIL directed_model[%0d] got %h want %h", i, {rc, rs},
                                model_add(ta[i], tb[i], tc[i]));
         end
`ifdef SERIAL_ADD_OVF_EN
         checks++;
         if (rv !== model_ovf(ta[i], tb[i], tc[i])) begin
            errors++; $display("FAIL directed_ovf[%0d] got %b want %b", i, rv, model_ovf(ta[i], tb[i], tc[i]));
         end
`endif
      end
   endtask

   task automatic test_random();
      int lat; logic [W-1:0] rs, va, vb; logic rc, rv, to, vc;
      for (int i = 0; i < 12; i++) begin
         va = 16'($urandom); vb = 16'($urandom); vc = 1'($urandom);
         run_op(va, vb, vc, lat, rs, rc, rv, to);
         checks++;
         if (to || {rc, rs} !== model_add(va, vb, vc)) begin
            errors++; $display("FAIL random[%0d] got %h (timeout %b) want %h", i, {rc, rs}, to, model_add(va, vb, vc));
         end
`ifdef SERIAL_ADD_OVF_EN
         checks++;
         if (rv !== model_ovf(va, vb, vc)) begin
            errors++; $display("FAIL random_ovf[%0d] got %b want %b", i, rv, model_ovf(va, vb, vc));
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] va, vb, hold;
      logic vc, seen;
      va = 16'($urandom); vb = 16'($urandom); vc = 1'($urandom);
      @(negedge clk);
      a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = out_valid;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL bp_timeout got no out_valid want out_valid"); end
      hold = sum;
      checks++;
      if ({cout, sum} !== model_add(va, vb, vc)) begin
         errors++; $display("FAIL bp_result got %h want %h", {cout, sum}, model_add(va, vb, vc));
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if (sum !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d] got sum %h in_ready %b out_valid %b want sum %h in_ready 0 out_valid 1",
                               k, sum, in_ready, out_valid, hold);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_accept got out_valid %b in_ready %b want out_valid 0 in_ready 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_midrun();
      logic seen;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0000) begin
         errors++; $display("FAIL midrun_reset got in_ready %b out_valid %b sum %h want 1 0 0000", in_ready, out_valid, sum);
      end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      out_ready = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_result got out_valid pulse %b want 0", seen); end
   endtask

   task automatic test_back_to_back();
      localparam int N = 5;
      logic [W-1:0] va [N], vb [N];
      logic         vc [N];
      logic [W:0]   exp_q [$];
      logic [W:0]   e;
      int idx, got, last;
      for (int i = 0; i < N; i++) begin
         va[i] = 16'($urandom); vb[i] = 16'($urandom); vc[i] = 1'($urandom);
      end
      idx = 0; got = 0; last = -1;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && got < N; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected got %h want no result", {cout, sum});
            end else begin
               e = exp_q.pop_front();
               if ({cout, sum} !== e) begin
                  errors++; $display("FAIL b2b_result[%0d] got %h want %h", got, {cout, sum}, e);
               end
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != NIB + 2) begin
                  errors++; $display("FAIL b2b_interval[%0d] got %0d want %0d", got, cyc - last, NIB + 2);
               end
            end
            last = cyc;
            got++;
         end
         if (idx < N) begin
            a = va[idx]; b = vb[idx]; cin = vc[idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_add(va[idx], vb[idx], vc[idx]));
            idx++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (got != N) begin errors++; $display("FAIL b2b_count got %0d want %0d", got, N); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_midrun();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
